// File: rtl/vc_domain_mux_pipe_if.sv
`default_nettype none
// vc_domain_mux_pipe_if: producer/consumer handshake bundle for the domain-tagged mux.
// rev 1.0
interface vc_domain_mux_pipe_if #(
  parameter int p_nbits  = 32,
  parameter int p_nports = 4
);
  localparam int c_selw = $clog2(p_nports);

  logic [p_nports-1:0]         in_val;
  logic [p_nports-1:0]         in_rdy;
  logic [p_nports*p_nbits-1:0] in_msg;
  logic [p_nports-1:0]         in_domain;
  logic [c_selw-1:0]           sel;
  logic                        out_val;
  logic                        out_rdy;
  logic [p_nbits-1:0]          out_msg;
  logic                        out_domain;
  logic [c_selw-1:0]           grant_id;

  modport master (
    output in_val, in_msg, in_domain, sel, out_rdy,
    input  in_rdy, out_val, out_msg, out_domain, grant_id
  );

  modport slave (
    input  in_val, in_msg, in_domain, sel, out_rdy,
    output in_rdy, out_val, out_msg, out_domain, grant_id
  );
endinterface
`default_nettype wire

// File: rtl/vc_domain_mux_pipe.sv
`default_nettype none
// vc_domain_mux_pipe: N-input domain-tagged mux with one registered, zero-scrubbed output stage.
// rev 1.0
module vc_domain_mux_pipe #(
  parameter int p_nbits  = 32,
  parameter int p_nports = 4,
  parameter int p_mode   = 0
) (
  input  logic                clk,
  input  logic                reset,
  vc_domain_mux_pipe_if.slave bus
);
  localparam int c_selw = $clog2(p_nports);

  logic               can_acc;
  logic [c_selw-1:0]  grant;
  logic               grant_ok;
  logic               xfer;
  logic [p_nbits-1:0] grant_msg;
  logic               grant_dom;

  // The stage may refill on the same cycle it drains.
  assign can_acc = !bus.out_val || bus.out_rdy;

  generate
    if (p_mode == 0) begin : g_sel
      assign grant    = bus.sel;
      assign grant_ok = ({1'b0, bus.sel} < (c_selw + 1)'(p_nports));
    end else begin : g_rr
      logic [c_selw-1:0] ptr;
      logic [c_selw:0]   pos;
      logic              unused_sel;

      assign unused_sel = ^bus.sel;

      // Walk offsets from the far end so the nearest valid channel after ptr wins.
      always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        pos      = '0;
        for (int k = p_nports - 1; k >= 0; k--) begin
          pos = {1'b0, ptr} + (c_selw + 1)'(k);
          if (pos >= (c_selw + 1)'(p_nports)) begin
            pos = pos - (c_selw + 1)'(p_nports);
          end
          for (int j = 0; j < p_nports; j++) begin
            if ((pos[c_selw-1:0] == c_selw'(j)) && bus.in_val[j]) begin
              grant    = c_selw'(j);
              grant_ok = 1'b1;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ptr <= '0;
        end else if (xfer) begin
          ptr <= (grant == c_selw'(p_nports - 1)) ? '0 : grant + c_selw'(1);
        end
      end
    end
  endgenerate

  always_comb begin
    bus.in_rdy = '0;
    grant_msg  = '0;
    grant_dom  = 1'b0;
    for (int i = 0; i < p_nports; i++) begin
      if (grant == c_selw'(i)) begin
        bus.in_rdy[i] = reset && grant_ok && can_acc;
        grant_msg     = bus.in_msg[i*p_nbits +: p_nbits];
        grant_dom     = bus.in_domain[i];
      end
    end
  end

  assign xfer = |(bus.in_val & bus.in_rdy);

  // Payload and domain label always move together; an emptied stage shows all zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_val    <= 1'b0;
      bus.out_msg    <= '0;
      bus.out_domain <= 1'b0;
      bus.grant_id   <= '0;
    end else if (xfer) begin
      bus.out_val    <= 1'b1;
      bus.out_msg    <= grant_msg;
      bus.out_domain <= grant_dom;
      bus.grant_id   <= grant;
    end else if (bus.out_rdy) begin
      bus.out_val    <= 1'b0;
      bus.out_msg    <= '0;
      bus.out_domain <= 1'b0;
      bus.grant_id   <= '0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_vc_domain_mux_pipe.sv
`default_nettype none
// tb_vc_domain_mux_pipe: three configurations (steered x4, round-robin x4, steered x3)
// checked every cycle against a queue-free behavioural model plus directed vectors.
module tb_vc_domain_mux_pipe;
  localparam int NP [3] = '{4, 4, 3};
  localparam int MD [3] = '{0, 1, 0};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_domain_mux_pipe_if #(.p_nbits(32), .p_nports(4)) b0 ();
  vc_domain_mux_pipe_if #(.p_nbits(32), .p_nports(4)) b1 ();
  vc_domain_mux_pipe_if #(.p_nbits(32), .p_nports(3)) b2 ();

  vc_domain_mux_pipe #(.p_nbits(32), .p_nports(4), .p_mode(0)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  vc_domain_mux_pipe #(.p_nbits(32), .p_nports(4), .p_mode(1)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  vc_domain_mux_pipe #(.p_nbits(32), .p_nports(3), .p_mode(0)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));

  // stimulus per DUT
  logic [3:0]   s_val  [3];
  logic [3:0]   s_dom  [3];
  logic [127:0] s_msg  [3];
  logic [1:0]   s_sel  [3];
  logic         s_ordy [3];

  assign b0.in_val = s_val[0];       assign b0.in_msg = s_msg[0];       assign b0.in_domain = s_dom[0];
  assign b0.sel    = s_sel[0];       assign b0.out_rdy = s_ordy[0];
  assign b1.in_val = s_val[1];       assign b1.in_msg = s_msg[1];       assign b1.in_domain = s_dom[1];
  assign b1.sel    = s_sel[1];       assign b1.out_rdy = s_ordy[1];
  assign b2.in_val = s_val[2][2:0];  assign b2.in_msg = s_msg[2][95:0]; assign b2.in_domain = s_dom[2][2:0];
  assign b2.sel    = s_sel[2];       assign b2.out_rdy = s_ordy[2];

  // observed outputs
  logic [3:0]  a_rdy [3];
  logic        a_val [3];
  logic [31:0] a_msg [3];
  logic        a_dom [3];
  logic [1:0]  a_gid [3];

  assign a_rdy[0] = b0.in_rdy;         assign a_val[0] = b0.out_val; assign a_msg[0] = b0.out_msg;
  assign a_dom[0] = b0.out_domain;     assign a_gid[0] = b0.grant_id;
  assign a_rdy[1] = b1.in_rdy;         assign a_val[1] = b1.out_val; assign a_msg[1] = b1.out_msg;
  assign a_dom[1] = b1.out_domain;     assign a_gid[1] = b1.grant_id;
  assign a_rdy[2] = {1'b0, b2.in_rdy}; assign a_val[2] = b2.out_val; assign a_msg[2] = b2.out_msg;
  assign a_dom[2] = b2.out_domain;     assign a_gid[2] = b2.grant_id;

  // reference model: one held slot per DUT plus the round-robin start point
  logic        m_val [3];
  logic [31:0] m_msg [3];
  logic        m_dom [3];
  int          m_gid [3];
  int          m_ptr [3];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h, expected %h", nm, d, act, exp);
    end
  endtask

  function automatic int pick(input int d);
    if (MD[d] == 0) return (int'(s_sel[d]) < NP[d]) ? int'(s_sel[d]) : -1;
    for (int k = 0; k < NP[d]; k++) begin
      int c;
      c = (m_ptr[d] + k) % NP[d];
      if (s_val[d][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(input int d);
    logic [3:0] r;
    int g;
    r = '0;
    g = pick(d);
    if (reset && g >= 0 && (!m_val[d] || s_ordy[d])) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_val[d] = 1'b0; m_msg[d] = '0; m_dom[d] = 1'b0; m_gid[d] = 0; m_ptr[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      int g;
      logic can;
      g   = pick(d);
      can = !m_val[d] || s_ordy[d];
      if (g >= 0 && can && s_val[d][g]) begin
        m_val[d] = 1'b1;
        m_msg[d] = s_msg[d][g*32 +: 32];
        m_dom[d] = s_dom[d][g];
        m_gid[d] = g;
        if (MD[d] == 1) m_ptr[d] = (g + 1) % NP[d];
      end else if (s_ordy[d]) begin
        m_val[d] = 1'b0; m_msg[d] = '0; m_dom[d] = 1'b0; m_gid[d] = 0;
      end
    end
  endtask

  task automatic check_rdy();
    for (int d = 0; d < 3; d++) chk("in_rdy", d, 32'(a_rdy[d]), 32'(exp_rdy(d)));
  endtask

  task automatic check_outs();
    for (int d = 0; d < 3; d++) begin
      chk("out_val", d, 32'(a_val[d]), 32'(m_val[d]));
      chk("out_msg", d, a_msg[d], m_msg[d]);
      chk("out_domain", d, 32'(a_dom[d]), 32'(m_dom[d]));
      chk("grant_id", d, 32'(a_gid[d]), 32'(m_gid[d]));
    end
  endtask

  // Inputs are set by the caller; readies checked before the edge, outputs 1 time unit after it.
  task automatic tick();
    #1;
    check_rdy();
    model_step();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  val;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [31:0] om;
    logic        od;
    logic [1:0]  gid;
  } vec_t;

  vec_t tbl [9];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd2};
    tbl[1] = '{2'd2, 4'b0000, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd2};
    tbl[2] = '{2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd2};
    tbl[3] = '{2'd1, 4'b0010, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b1, 2'd2};
    tbl[4] = '{2'd1, 4'b0000, 1'b1, 4'b0010, 1'b0, 32'h0000_0000, 1'b0, 2'd0};
    tbl[5] = '{2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 32'hCAFE_F00D, 1'b0, 2'd3};
    tbl[6] = '{2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 32'h0000_1111, 1'b0, 2'd0};
    tbl[7] = '{2'd0, 4'b1110, 1'b1, 4'b0001, 1'b0, 32'h0000_0000, 1'b0, 2'd0};
    tbl[8] = '{2'd1, 4'b0010, 1'b0, 4'b0010, 1'b1, 32'h2222_0000, 1'b0, 2'd1};

    for (int d = 0; d < 3; d++) begin
      s_val[d] = '0; s_dom[d] = 4'b0100; s_sel[d] = '0; s_ordy[d] = 1'b1;
      s_msg[d] = {32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h2222_0000, 32'h0000_1111};
    end
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    check_rdy();
    reset = 1'b1;

    // directed vectors on the steered 4-port instance
    foreach (tbl[i]) begin
      s_sel[0] = tbl[i].sel; s_val[0] = tbl[i].val; s_ordy[0] = tbl[i].ordy;
      #1;
      chk("tbl_rdy", 0, 32'(a_rdy[0]), 32'(tbl[i].rdy));
      tick();
      chk("tbl_val", 0, 32'(a_val[0]), 32'(tbl[i].ov));
      chk("tbl_msg", 0, a_msg[0], tbl[i].om);
      chk("tbl_dom", 0, 32'(a_dom[0]), 32'(tbl[i].od));
      chk("tbl_gid", 0, 32'(a_gid[0]), 32'(tbl[i].gid));
    end

    // asynchronous reset while an entry is held
    s_sel[0] = 2'd2; s_val[0] = 4'b0100; s_ordy[0] = 1'b0;
    tick();
    chk("pre_rst_val", 0, 32'(a_val[0]), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_val", 0, 32'(a_val[0]), 32'd0);
    chk("rst_msg", 0, a_msg[0], 32'd0);
    chk("rst_dom", 0, 32'(a_dom[0]), 32'd0);
    chk("rst_rdy", 0, 32'(a_rdy[0]), 32'd0);
    check_outs();
    #1;
    reset = 1'b1;
    #1;
    chk("rel_rdy", 0, 32'(a_rdy[0]), 32'b0100);
    s_val[0] = 4'b0000; s_ordy[0] = 1'b1;
    tick();
    tick();

    // round-robin fairness with every channel requesting
    s_val[1] = 4'b1111; s_ordy[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_gid", 1, 32'(a_gid[1]), 32'(i % 4));
      chk("rr_val", 1, 32'(a_val[1]), 32'd1);
    end

    // wrap and skip: move ptr to 3, then only channel 1 requests
    s_val[1] = 4'b0100;
    tick();
    chk("rr_set", 1, 32'(a_gid[1]), 32'd2);
    s_val[1] = 4'b0010;
    tick();
    chk("rr_wrap", 1, 32'(a_gid[1]), 32'd1);
    s_val[1] = 4'b1011;
    tick();
    chk("rr_ptr2", 1, 32'(a_gid[1]), 32'd3);
    s_val[1] = 4'b0000;
    tick();

    // out-of-range select on the 3-port instance
    s_sel[2] = 2'd3; s_val[2] = 4'b0111; s_ordy[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bad_sel_rdy", 2, 32'(a_rdy[2]), 32'd0);
      chk("bad_sel_val", 2, 32'(a_val[2]), 32'd0);
    end

    // randomized traffic, with an occasional asynchronous reset pulse
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 3; d++) begin
        s_val[d]  = 4'($urandom);
        s_dom[d]  = 4'($urandom);
        s_sel[d]  = 2'($urandom);
        s_ordy[d] = ($urandom_range(0, 3) != 0);
        s_msg[d]  = {$urandom, $urandom, $urandom, $urandom};
      end
      if (i % 100 == 50) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_outs();
        reset = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
